// File: rtl/pe_result_streamer.sv
// Drains VECTOR_SIZE result words from the shared BRAM into one AXI4-Stream packet.
// Read data is staged through a small credit-controlled FIFO so backpressure never loses a word.
module pe_result_streamer #(
    parameter int          VECTOR_SIZE = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] BRAM_ADDR,
    output logic        BRAM_EN,
    output logic [3:0]  BRAM_WE,
    input  logic [31:0] BRAM_RDDATA,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast
);

    localparam int IDX_W = $clog2(VECTOR_SIZE + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(VECTOR_SIZE - 1);
    localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  out_idx;
    logic              rd_vld_p1;
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              credit_ok;
    logic              push;
    logic              pop;
    logic              last_beat;

    // Occupancy counts reads already in flight so the FIFO can never overflow.
    assign credit_ok = ((CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(rd_vld_p1)) < DEPTH_LIM;
    assign push      = rd_vld_p1;
    assign pop       = m_axis_tvalid & m_axis_tready;
    assign last_beat = pop & m_axis_tlast;

    assign BRAM_WE       = 4'h0;
    assign BRAM_ADDR     = BASE_ADDR + (32'(rd_idx) << 2);
    assign m_axis_tvalid = (fifo_count != '0);
    assign m_axis_tlast  = m_axis_tvalid & (out_idx == LAST_IDX);
    assign m_axis_tdata  = m_axis_tvalid ? fifo_mem[rd_ptr] : 32'h0;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_READ;
            S_READ:  if (BRAM_EN && (rd_idx == LAST_IDX)) state_nxt = S_DRAIN;
            S_DRAIN: if (last_beat) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        BRAM_EN = (state == S_READ) && credit_ok;
    end

    // Stage p0 -> p1: read issued this cycle, data valid on BRAM_RDDATA next cycle.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_idx     <= '0;
            out_idx    <= '0;
            rd_vld_p1  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            rd_vld_p1 <= BRAM_EN;
            if (BRAM_EN) begin
                rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + IDX_W'(1);
            end
            if (pop) begin
                out_idx <= last_beat ? '0 : out_idx + IDX_W'(1);
                rd_ptr  <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    // Stage p1 -> FIFO: capture returned read data.
    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= BRAM_RDDATA;
        end
    end

endmodule

// File: tb/tb_pe_result_streamer.sv
// Randomized bench for pe_result_streamer: BRAM model, stream monitor and an
// in-order expected-word model derived from BRAM contents.
module tb_pe_result_streamer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start, start_b;
    logic        busy, done, busy_b, done_b;
    logic [31:0] bram_addr, bram_addr_b;
    logic        bram_en, bram_en_b;
    logic [3:0]  bram_we, bram_we_b;
    logic [31:0] bram_rddata, bram_rddata_b;
    logic [31:0] tdata, tdata_b;
    logic        tvalid, tvalid_b;
    logic        tready, tready_b;
    logic        tlast, tlast_b;

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [8];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // monitor state (written only by the monitor processes)
    logic [31:0] hs_data [$];
    bit          hs_last [$];
    int          hs_cyc  [$];
    logic [31:0] rd_addr_q [$];
    int done_cnt = 0, done_cyc = 0, rd_total = 0, hs_total = 0, occ_max = 0, stab_err = 0;
    logic [31:0] hsb_data [$];
    bit          hsb_last [$];
    logic [31:0] rdb_addr_q [$];
    int doneb_cnt = 0;

    pe_result_streamer #(.VECTOR_SIZE(64), .BASE_ADDR(32'h0), .FIFO_DEPTH(4)) dut_a (
        .aclk(aclk), .aresetn(aresetn), .start(start), .busy(busy), .done(done),
        .BRAM_ADDR(bram_addr), .BRAM_EN(bram_en), .BRAM_WE(bram_we), .BRAM_RDDATA(bram_rddata),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast)
    );

    pe_result_streamer #(.VECTOR_SIZE(8), .BASE_ADDR(32'h100), .FIFO_DEPTH(4)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .start(start_b), .busy(busy_b), .done(done_b),
        .BRAM_ADDR(bram_addr_b), .BRAM_EN(bram_en_b), .BRAM_WE(bram_we_b), .BRAM_RDDATA(bram_rddata_b),
        .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b), .m_axis_tlast(tlast_b)
    );

    always #5 aclk = ~aclk;

    initial begin
        forever begin
            @(posedge aclk);
            cyc++;
        end
    end

    // BRAM models: one-cycle read latency
    logic [31:0] offb;
    assign offb = bram_addr_b - 32'h100;
    always @(posedge aclk) begin
        if (bram_en) bram_rddata <= mem_a[bram_addr[7:2]];
        if (bram_en_b) bram_rddata_b <= mem_b[offb[4:2]];
    end

    // Stream/BRAM monitor for the 64-word instance
    initial begin
        bit p_vld, p_hs, p_last, p_ok;
        logic [31:0] p_data;
        p_vld = 0; p_hs = 0; p_last = 0; p_ok = 0; p_data = '0;
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                if (rd_total - hs_total > occ_max) occ_max = rd_total - hs_total;
                if (p_ok && p_vld && !p_hs && (!tvalid || tdata !== p_data || tlast !== p_last))
                    stab_err++;
                if (tlast && !tvalid) stab_err++;
                if (bram_en) begin
                    rd_addr_q.push_back(bram_addr);
                    rd_total++;
                end
                if (tvalid && tready) begin
                    hs_data.push_back(tdata);
                    hs_last.push_back(tlast);
                    hs_cyc.push_back(cyc);
                    hs_total++;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end else begin
                rd_total = hs_total;
            end
            p_vld = tvalid; p_hs = tvalid && tready; p_data = tdata; p_last = tlast; p_ok = aresetn;
        end
    end

    // Monitor for the 8-word instance
    initial begin
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                if (bram_en_b) rdb_addr_q.push_back(bram_addr_b);
                if (tvalid_b && tready_b) begin
                    hsb_data.push_back(tdata_b);
                    hsb_last.push_back(tlast_b);
                end
                if (done_b) doneb_cnt++;
            end
        end
    end

    task automatic pulse_start(output int s);
        @(posedge aclk); #1;
        start = 1'b1;
        s = cyc;
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    // mode: 0 ready high, 1 alternating, 2 ready low, 3 random
    task automatic run_until_done(input int mode, input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge aclk); #1;
            case (mode)
                0: tready = 1'b1;
                1: tready = (i % 2 == 0);
                2: tready = 1'b0;
                default: tready = 1'($urandom_range(0, 1));
            endcase
            if (done_cnt > d0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        aresetn = 1'b0; start = 1'b0; start_b = 1'b0; tready = 1'b0; tready_b = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        n_cmp++;
        if ({busy, done, bram_en, tvalid, tlast} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctl_in_reset: got %b expected 00000", {busy, done, bram_en, tvalid, tlast});
        end
        n_cmp++;
        if (bram_addr !== 32'h0 || tdata !== 32'h0 || bram_we !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_addr_data: got addr=%h data=%h we=%h expected 0/0/0", bram_addr, tdata, bram_we);
        end
        n_cmp++;
        if (bram_addr_b !== 32'h100 || tvalid_b !== 1'b0 || bram_we_b !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_b: got addr=%h tvalid=%b we=%h expected 100/0/0", bram_addr_b, tvalid_b, bram_we_b);
        end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        n_cmp++;
        if ({busy, done, bram_en, tvalid, tlast} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctl_after: got %b expected 00000", {busy, done, bram_en, tvalid, tlast});
        end
    endtask

    task automatic test_single_packet;
        int s, hb, rb, db, sb, n;
        bit ok;
        logic [31:0] exp_q [$];
        for (int i = 0; i < 64; i++) mem_a[i] = 32'hA000_0000 + i;
        for (int i = 0; i < 64; i++) exp_q.push_back(mem_a[i]);
        hb = hs_data.size(); rb = rd_addr_q.size(); db = done_cnt; sb = stab_err;
        tready = 1'b1;
        pulse_start(s);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_busy: got %b expected 1", busy);
        end
        run_until_done(0, 300, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL t1_timeout: got no done expected done");
        end
        n = hs_data.size() - hb;
        n_cmp++;
        if (n != 64) begin
            n_fail++;
            $display("FAIL t1_beats: got %0d expected 64", n);
        end
        for (int i = 0; i < 64 && i < n; i++) begin
            n_cmp++;
            if (hs_data[hb+i] !== exp_q[i] || hs_last[hb+i] !== (i == 63)) begin
                n_fail++;
                $display("FAIL t1_beat%0d: got %h/%b expected %h/%b", i, hs_data[hb+i], hs_last[hb+i], exp_q[i], i == 63);
            end
            if (i > 0) begin
                n_cmp++;
                if (hs_cyc[hb+i] != hs_cyc[hb+i-1] + 1) begin
                    n_fail++;
                    $display("FAIL t1_gap%0d: got cycle %0d expected %0d", i, hs_cyc[hb+i], hs_cyc[hb+i-1] + 1);
                end
            end
        end
        if (n > 0) begin
            n_cmp++;
            if (hs_cyc[hb] != s + 3) begin
                n_fail++;
                $display("FAIL t1_first_latency: got %0d expected %0d", hs_cyc[hb] - s, 3);
            end
            n_cmp++;
            if (done_cyc != hs_cyc[hb+n-1] + 1) begin
                n_fail++;
                $display("FAIL t1_done_latency: got %0d expected %0d", done_cyc, hs_cyc[hb+n-1] + 1);
            end
        end
        n_cmp++;
        if (done_cnt - db != 1) begin
            n_fail++;
            $display("FAIL t1_done_count: got %0d expected 1", done_cnt - db);
        end
        n_cmp++;
        if (rd_addr_q.size() - rb != 64) begin
            n_fail++;
            $display("FAIL t1_reads: got %0d expected 64", rd_addr_q.size() - rb);
        end
        for (int i = 0; i < 64 && rb + i < rd_addr_q.size(); i++) begin
            n_cmp++;
            if (rd_addr_q[rb+i] !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL t1_addr%0d: got %h expected %h", i, rd_addr_q[rb+i], 32'(4 * i));
            end
        end
        n_cmp++;
        if (stab_err != sb) begin
            n_fail++;
            $display("FAIL t1_axis_hold: got %0d violations expected 0", stab_err - sb);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_backpressure(input int mode, input string tag);
        int s, hb, rb, sb, n;
        bit ok;
        logic [31:0] exp_q [$];
        for (int i = 0; i < 64; i++) mem_a[i] = $urandom;
        for (int i = 0; i < 64; i++) exp_q.push_back(mem_a[i]);
        hb = hs_data.size(); rb = rd_addr_q.size(); sb = stab_err;
        tready = 1'b1;
        pulse_start(s);
        run_until_done(mode, 1000, ok);
        n = hs_data.size() - hb;
        n_cmp++;
        if (!ok || n != 64) begin
            n_fail++;
            $display("FAIL %s_beats: got %0d (done=%b) expected 64", tag, n, ok);
        end
        for (int i = 0; i < 64 && i < n; i++) begin
            n_cmp++;
            if (hs_data[hb+i] !== exp_q[i] || hs_last[hb+i] !== (i == 63)) begin
                n_fail++;
                $display("FAIL %s_beat%0d: got %h/%b expected %h/%b", tag, i, hs_data[hb+i], hs_last[hb+i], exp_q[i], i == 63);
            end
        end
        n_cmp++;
        if (rd_addr_q.size() - rb != 64) begin
            n_fail++;
            $display("FAIL %s_reads: got %0d expected 64", tag, rd_addr_q.size() - rb);
        end
        n_cmp++;
        if (occ_max > 4) begin
            n_fail++;
            $display("FAIL %s_occupancy: got %0d expected <=4", tag, occ_max);
        end
        n_cmp++;
        if (stab_err != sb) begin
            n_fail++;
            $display("FAIL %s_axis_hold: got %0d violations expected 0", tag, stab_err - sb);
        end
        if (mode == 1) begin
            n_cmp++;
            if (occ_max != 4) begin
                n_fail++;
                $display("FAIL %s_throttle_peak: got %0d expected 4", tag, occ_max);
            end
        end
        tready = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic test_stall;
        int s, hb, rb, sb, n;
        bit ok;
        for (int i = 0; i < 64; i++) mem_a[i] = $urandom;
        hb = hs_data.size(); rb = rd_addr_q.size(); sb = stab_err;
        tready = 1'b0;
        pulse_start(s);
        run_until_done(2, 19, ok);
        @(negedge aclk);
        n_cmp++;
        if (rd_addr_q.size() - rb != 4) begin
            n_fail++;
            $display("FAIL t3_reads_stalled: got %0d expected 4", rd_addr_q.size() - rb);
        end
        for (int i = 0; i < 4 && rb + i < rd_addr_q.size(); i++) begin
            n_cmp++;
            if (rd_addr_q[rb+i] !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL t3_addr%0d: got %h expected %h", i, rd_addr_q[rb+i], 32'(4 * i));
            end
        end
        n_cmp++;
        if (tvalid !== 1'b1 || tdata !== mem_a[0] || tlast !== 1'b0 || bram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_head: got v=%b d=%h l=%b en=%b expected 1/%h/0/0", tvalid, tdata, tlast, bram_en, mem_a[0]);
        end
        run_until_done(0, 300, ok);
        n = hs_data.size() - hb;
        n_cmp++;
        if (!ok || n != 64) begin
            n_fail++;
            $display("FAIL t3_beats: got %0d expected 64", n);
        end
        for (int i = 0; i < 64 && i < n; i++) begin
            n_cmp++;
            if (hs_data[hb+i] !== mem_a[i]) begin
                n_fail++;
                $display("FAIL t3_beat%0d: got %h expected %h", i, hs_data[hb+i], mem_a[i]);
            end
        end
        n_cmp++;
        if (stab_err != sb) begin
            n_fail++;
            $display("FAIL t3_axis_hold: got %0d violations expected 0", stab_err - sb);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_restart_ignored;
        int s, hb, db, n;
        bit ok;
        for (int i = 0; i < 64; i++) mem_a[i] = $urandom;
        hb = hs_data.size(); db = done_cnt;
        tready = 1'b1;
        pulse_start(s);
        for (int i = 0; i < 100; i++) begin
            if (hs_data.size() - hb >= 10) break;
            @(posedge aclk); #1;
        end
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        run_until_done(0, 300, ok);
        repeat (80) @(posedge aclk);
        @(negedge aclk);
        n = hs_data.size() - hb;
        n_cmp++;
        if (n != 64) begin
            n_fail++;
            $display("FAIL t4_beats: got %0d expected 64", n);
        end
        n_cmp++;
        if (done_cnt - db != 1) begin
            n_fail++;
            $display("FAIL t4_done_count: got %0d expected 1", done_cnt - db);
        end
        for (int i = 0; i < 64 && i < n; i++) begin
            n_cmp++;
            if (hs_data[hb+i] !== mem_a[i] || hs_last[hb+i] !== (i == 63)) begin
                n_fail++;
                $display("FAIL t4_beat%0d: got %h/%b expected %h/%b", i, hs_data[hb+i], hs_last[hb+i], mem_a[i], i == 63);
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_idle_after: got busy=%b tvalid=%b expected 0/0", busy, tvalid);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_reset_mid_packet;
        int s, hb, db, n;
        bit ok;
        for (int i = 0; i < 64; i++) mem_a[i] = $urandom;
        hb = hs_data.size(); db = done_cnt;
        tready = 1'b1;
        pulse_start(s);
        for (int i = 0; i < 100; i++) begin
            if (hs_data.size() - hb >= 30) break;
            @(posedge aclk); #1;
        end
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        n_cmp++;
        if ({tvalid, tlast, busy, bram_en} !== 4'b0) begin
            n_fail++;
            $display("FAIL t5_after_reset: got %b expected 0000", {tvalid, tlast, busy, bram_en});
        end
        repeat (10) @(posedge aclk);
        #1;
        n_cmp++;
        if (done_cnt != db) begin
            n_fail++;
            $display("FAIL t5_no_done: got %0d expected 0", done_cnt - db);
        end
        for (int i = 0; i < 64; i++) mem_a[i] = $urandom;
        hb = hs_data.size();
        pulse_start(s);
        run_until_done(3, 1000, ok);
        n = hs_data.size() - hb;
        n_cmp++;
        if (!ok || n != 64) begin
            n_fail++;
            $display("FAIL t5_new_beats: got %0d expected 64", n);
        end
        for (int i = 0; i < 64 && i < n; i++) begin
            n_cmp++;
            if (hs_data[hb+i] !== mem_a[i] || hs_last[hb+i] !== (i == 63)) begin
                n_fail++;
                $display("FAIL t5_beat%0d: got %h/%b expected %h/%b", i, hs_data[hb+i], hs_last[hb+i], mem_a[i], i == 63);
            end
        end
        tready = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic test_small_instance;
        int hb, rb, db, n;
        bit ok;
        for (int i = 0; i < 8; i++) mem_b[i] = $urandom;
        hb = hsb_data.size(); rb = rdb_addr_q.size(); db = doneb_cnt;
        tready_b = 1'b1;
        @(posedge aclk); #1;
        start_b = 1'b1;
        @(posedge aclk); #1;
        start_b = 1'b0;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge aclk); #1;
            tready_b = 1'($urandom_range(0, 1));
            if (doneb_cnt > db) begin
                ok = 1;
                break;
            end
        end
        n = hsb_data.size() - hb;
        n_cmp++;
        if (!ok || n != 8) begin
            n_fail++;
            $display("FAIL t6_beats: got %0d expected 8", n);
        end
        for (int i = 0; i < 8 && i < n; i++) begin
            n_cmp++;
            if (hsb_data[hb+i] !== mem_b[i] || hsb_last[hb+i] !== (i == 7)) begin
                n_fail++;
                $display("FAIL t6_beat%0d: got %h/%b expected %h/%b", i, hsb_data[hb+i], hsb_last[hb+i], mem_b[i], i == 7);
            end
        end
        n_cmp++;
        if (rdb_addr_q.size() - rb != 8) begin
            n_fail++;
            $display("FAIL t6_reads: got %0d expected 8", rdb_addr_q.size() - rb);
        end
        for (int i = 0; i < 8 && rb + i < rdb_addr_q.size(); i++) begin
            n_cmp++;
            if (rdb_addr_q[rb+i] !== 32'h100 + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL t6_addr%0d: got %h expected %h", i, rdb_addr_q[rb+i], 32'h100 + 32'(4 * i));
            end
        end
        tready_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_backpressure(1, "t2_alt");
        test_stall();
        test_restart_ignored();
        test_reset_mid_packet();
        test_backpressure(3, "rand_ready");
        test_small_instance();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
